// File: rtl/uart_apb_sequencer.sv
// APB3 master that configures one UART slave, then polls its status register and
// moves bytes between the UART and a TX input stream and an RX output stream.
module uart_apb_sequencer #(
    parameter logic [12:0] BAUD_VALUE = 13'd1,
    parameter logic        BIT8       = 1'b1,
    parameter logic        PARITY_EN  = 1'b0,
    parameter logic        ODD_N_EVEN = 1'b0,
    parameter logic        FRAC_EN    = 1'b0,
    parameter logic [2:0]  BAUD_FRAC  = 3'd0,
    parameter logic [3:0]  POLL_GAP   = 4'd0
) (
    input  logic       PCLK,
    input  logic       PRESETN,
    output logic [4:0] M_PADDR,
    output logic       M_PSEL,
    output logic       M_PENABLE,
    output logic       M_PWRITE,
    output logic [7:0] M_PWDATA,
    input  logic [7:0] M_PRDATA,
    input  logic       M_PREADY,
    input  logic       cfg_req,
    output logic       cfg_done,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic [2:0] rx_err,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic [7:0] ovf_cnt
);
    localparam logic [4:0] A_TX    = 5'h00;
    localparam logic [4:0] A_RX    = 5'h04;
    localparam logic [4:0] A_CTRL1 = 5'h08;
    localparam logic [4:0] A_CTRL2 = 5'h0C;
    localparam logic [4:0] A_STAT  = 5'h10;
    localparam logic [4:0] A_CTRL3 = 5'h14;

    typedef enum logic [2:0] {CFG1, CFG2, CFG3, POLL, RXRD, TXWR, GAP} state_t;

    state_t     state, nxt_st, entry_st;
    logic       ptr_tx, cfg_pend, hold_full;
    logic [7:0] hold;
    logic [2:0] stat_q;
    logic [3:0] gap_cnt;
    logic       done, cfg_take, rx_want, tx_want, launch, gap_go, last_cfg;

    function automatic logic [4:0] addr_of(input state_t s);
        case (s)
            CFG1:    return A_CTRL1;
            CFG2:    return A_CTRL2;
            CFG3:    return A_CTRL3;
            RXRD:    return A_RX;
            TXWR:    return A_TX;
            default: return A_STAT;
        endcase
    endfunction

    function automatic logic [7:0] data_of(input state_t s, input logic [7:0] h);
        case (s)
            CFG1:    return BAUD_VALUE[7:0];
            CFG2:    return {BAUD_VALUE[12:8], ODD_N_EVEN, PARITY_EN, BIT8};
            CFG3:    return {5'b00000, BAUD_FRAC};
            TXWR:    return h;
            default: return 8'h00;
        endcase
    endfunction

    // launch = a SETUP phase begins at the next edge for nxt_st; completions chain
    // straight into the next SETUP so back-to-back accesses take two cycles each.
    always_comb begin
        done     = M_PSEL & M_PENABLE & M_PREADY;
        cfg_take = cfg_pend | cfg_req;
        entry_st = cfg_take ? CFG1 : POLL;
        rx_want  = M_PRDATA[1] & ~rx_valid;
        tx_want  = M_PRDATA[0] & hold_full;
        launch   = 1'b0;
        gap_go   = 1'b0;
        last_cfg = 1'b0;
        nxt_st   = entry_st;
        case (state)
            CFG1: begin
                launch = ~M_PSEL | done;
                nxt_st = M_PSEL ? CFG2 : CFG1;
            end
            CFG2: begin
                launch   = done;
                last_cfg = done & ~FRAC_EN;
                nxt_st   = FRAC_EN ? CFG3 : entry_st;
            end
            CFG3: begin
                launch   = done;
                last_cfg = done;
            end
            POLL: begin
                if (done) begin
                    if (rx_want && tx_want) nxt_st = ptr_tx ? TXWR : RXRD;
                    else if (rx_want)       nxt_st = RXRD;
                    else if (tx_want)       nxt_st = TXWR;
                    launch = rx_want | tx_want | (POLL_GAP == 4'd0);
                    gap_go = ~launch;
                end
            end
            RXRD, TXWR: launch = done;
            GAP:        launch = (gap_cnt == 4'd0);
            default:    launch = 1'b0;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state     <= CFG1;
            M_PADDR   <= '0;
            M_PSEL    <= 1'b0;
            M_PENABLE <= 1'b0;
            M_PWRITE  <= 1'b0;
            M_PWDATA  <= '0;
            cfg_done  <= 1'b0;
            tx_ready  <= 1'b0;
            rx_data   <= '0;
            rx_err    <= '0;
            rx_valid  <= 1'b0;
            ovf_cnt   <= '0;
            ptr_tx    <= 1'b0;
            cfg_pend  <= 1'b0;
            hold      <= '0;
            hold_full <= 1'b0;
            stat_q    <= '0;
            gap_cnt   <= '0;
        end else begin
            if (cfg_req) cfg_pend <= 1'b1;
            if (tx_valid && tx_ready) begin
                hold      <= tx_data;
                hold_full <= 1'b1;
                tx_ready  <= 1'b0;
            end
            if (rx_valid && rx_ready) rx_valid <= 1'b0;
            if (done) begin
                case (state)
                    POLL: begin
                        stat_q <= M_PRDATA[4:2];
                        if (M_PRDATA[3] && ovf_cnt != 8'hFF) ovf_cnt <= ovf_cnt + 8'd1;
                        if (rx_want && tx_want) ptr_tx <= ~ptr_tx;
                    end
                    RXRD: begin
                        rx_data  <= M_PRDATA;
                        rx_err   <= stat_q;
                        rx_valid <= 1'b1;
                    end
                    TXWR: begin
                        hold_full <= 1'b0;
                        tx_ready  <= 1'b1;
                    end
                    default: ;
                endcase
            end
            if (last_cfg) begin
                cfg_done <= 1'b1;
                tx_ready <= ~hold_full;
            end
            // A pending reconfiguration entered here overrides the flags set above.
            if (launch) begin
                state     <= nxt_st;
                M_PSEL    <= 1'b1;
                M_PENABLE <= 1'b0;
                M_PADDR   <= addr_of(nxt_st);
                M_PWRITE  <= (nxt_st != POLL) && (nxt_st != RXRD);
                M_PWDATA  <= data_of(nxt_st, hold);
                if (nxt_st == CFG1) begin
                    cfg_pend <= 1'b0;
                    cfg_done <= 1'b0;
                    tx_ready <= 1'b0;
                end
            end else if (gap_go) begin
                state     <= GAP;
                gap_cnt   <= POLL_GAP - 4'd1;
                M_PSEL    <= 1'b0;
                M_PENABLE <= 1'b0;
            end else if (M_PSEL) begin
                M_PENABLE <= 1'b1;
            end else if (state == GAP) begin
                gap_cnt <= gap_cnt - 4'd1;
            end
        end
    end
endmodule
